// File: rtl/inject_ni_fifo.sv
// rtl/inject_ni_fifo.sv - network-interface injection FIFO with self-address filter and drop/self/sent statistics
//
// Captures single-cycle words from a source that cannot be stalled and presents them
// first-word fall-through to the local router under a valid/ready handshake.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   in_data     20-bit word from the source; bits [7:4] hold the destination node id
//   in_valid    single-cycle qualifier for in_data
//   flit_out    head-of-FIFO word toward the router
//   flit_valid  flit_out holds a valid word
//   flit_ready  router accepts flit_out this cycle
//   fifo_count  current occupancy (0..DEPTH)
//   full        occupancy equals DEPTH
//   empty       occupancy is zero
//   drop_count  words lost to overflow, saturating at 255
//   self_count  self-addressed words discarded, saturating at 255
//   sent_count  words handed to the router, saturating at 255
module inject_ni_fifo #(
    parameter int          DEPTH   = 8,
    parameter logic [3:0]  NODE_ID = 4'd0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [19:0]                 in_data,
    input  logic                        in_valid,
    output logic [19:0]                 flit_out,
    output logic                        flit_valid,
    input  logic                        flit_ready,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic                        full,
    output logic                        empty,
    output logic [7:0]                  drop_count,
    output logic [7:0]                  self_count,
    output logic [7:0]                  sent_count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [19:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;

    logic is_self;
    logic push_ok;
    logic push_drop;
    logic pop;

    assign full       = (cnt == FULL_CNT);
    assign empty      = (cnt == '0);
    assign fifo_count = cnt;
    assign flit_valid = ~empty;
    assign flit_out   = mem[rp];

    // Self filtering is decided before the full check, so a self-addressed word
    // arriving while full is counted as self, not as a drop. Full is taken from
    // the registered count, so a same-cycle pop never frees room for a push.
    assign is_self   = (in_data[7:4] == NODE_ID);
    assign push_ok   = in_valid && !is_self && !full;
    assign push_drop = in_valid && !is_self && full;
    assign pop       = flit_valid && flit_ready;

    // Storage is intentionally not reset; the head word is don't-care while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wp] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push_ok) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + (AW + 1)'(1);
                2'b01:   cnt <= cnt - (AW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_count <= '0;
            self_count <= '0;
            sent_count <= '0;
        end else begin
            if (push_drop && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
            if (in_valid && is_self && self_count != 8'hFF) begin
                self_count <= self_count + 8'd1;
            end
            if (pop && sent_count != 8'hFF) begin
                sent_count <= sent_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_inject_ni_fifo.sv
// tb/tb_inject_ni_fifo.sv - directed self-checking bench for inject_ni_fifo
module tb_inject_ni_fifo;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic [19:0] in_data;
    logic        in_valid;
    logic [19:0] flit_out;
    logic        flit_valid;
    logic        flit_ready;
    logic [3:0]  fifo_count;
    logic        full;
    logic        empty;
    logic [7:0]  drop_count;
    logic [7:0]  self_count;
    logic [7:0]  sent_count;

    int n_cmp = 0;
    int n_err = 0;

    inject_ni_fifo #(.DEPTH(DEPTH), .NODE_ID(4'd5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .flit_out   (flit_out),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .fifo_count (fifo_count),
        .full       (full),
        .empty      (empty),
        .drop_count (drop_count),
        .self_count (self_count),
        .sent_count (sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [19:0] q[$];
    logic [19:0] w;
    logic [19:0] prev_out;
    logic        prev_stall;
    int          sent_m;
    int          drop_m;
    bit          pushes;

    initial begin
        rst        = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        flit_ready = 1'b0;
        step();

        // reset state
        chk("rst_valid", 32'(flit_valid), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full",  32'(full), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_drop",  32'(drop_count), 0);
        chk("rst_self",  32'(self_count), 0);
        chk("rst_sent",  32'(sent_count), 0);
        rst = 1'b1;

        // order and latency: consecutive pushes with ready high
        flit_ready = 1'b1;
        in_valid   = 1'b1;
        in_data = 20'h00011; step();
        chk("ord_v1", 32'(flit_valid), 1);
        chk("ord_d1", 32'(flit_out), 32'h00011);
        in_data = 20'h00022; step();
        chk("ord_d2", 32'(flit_out), 32'h00022);
        chk("ord_c2", 32'(fifo_count), 1);
        in_data = 20'h00033; step();
        chk("ord_d3", 32'(flit_out), 32'h00033);
        in_valid = 1'b0; step();
        chk("ord_empty", 32'(empty), 1);
        chk("ord_sent",  32'(sent_count), 3);

        // overflow: 10 pushes with ready low
        flit_ready = 1'b0;
        in_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w = 20'h00010 | 20'(i << 8);
            in_data = w;
            step();
            if (i == 7) begin
                chk("ovf_full8",  32'(full), 1);
                chk("ovf_count8", 32'(fifo_count), 8);
            end
        end
        chk("ovf_drop", 32'(drop_count), 2);
        chk("ovf_head", 32'(flit_out), 32'h00010);

        // full with simultaneous pop and push: push is dropped
        flit_ready = 1'b1;
        in_data    = 20'h0AA10;
        step();
        chk("fpp_drop",  32'(drop_count), 3);
        chk("fpp_count", 32'(fifo_count), 7);
        chk("fpp_full",  32'(full), 0);

        // drain the remaining words in arrival order
        in_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            w = 20'h00010 | 20'(i << 8);
            chk("drain_data", 32'(flit_out), 32'(w));
            step();
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_sent",  32'(sent_count), 11);

        // self-address filter, NODE_ID = 5
        flit_ready = 1'b0;
        in_valid   = 1'b1;
        in_data = 20'h00055; step();
        chk("self_cnt0",  32'(fifo_count), 0);
        chk("self_count", 32'(self_count), 1);
        in_data = 20'h00066; step();
        chk("self_cnt1", 32'(fifo_count), 1);
        chk("self_head", 32'(flit_out), 32'h00066);
        in_valid   = 1'b0;
        flit_ready = 1'b1;
        step();
        chk("self_empty", 32'(empty), 1);

        // backpressure burst with random ready and a queue model
        sent_m     = 12;
        drop_m     = 3;
        prev_stall = 1'b0;
        prev_out   = '0;
        for (int i = 0; i < 50; i++) begin
            pushes     = (i < 30);
            in_valid   = pushes;
            in_data    = 20'h20010 | 20'(i << 8);
            flit_ready = 1'($urandom_range(0, 1));
            chk("bp_valid", 32'(flit_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("bp_data", 32'(flit_out), 32'(q[0]));
            if (prev_stall) chk("bp_stable", 32'(flit_out), 32'(prev_out));
            prev_stall = flit_valid && !flit_ready;
            prev_out   = flit_out;
            if (q.size() != 0 && flit_ready) begin
                void'(q.pop_front());
                sent_m++;
            end
            if (pushes) begin
                if (q.size() + ((flit_ready && q.size() != 0) ? 1 : 0) >= DEPTH) begin
                    drop_m++;
                end else begin
                    q.push_back(in_data);
                end
            end
            step();
            if (!pushes && q.size() == 0) break;
        end
        in_valid   = 1'b0;
        flit_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            chk("bp_drain", 32'(flit_out), 32'(q[0]));
            void'(q.pop_front());
            sent_m++;
            step();
        end
        chk("bp_empty", 32'(empty), 1);
        chk("bp_sent",  32'(sent_count), 32'((sent_m > 255) ? 255 : sent_m));
        chk("bp_drops", 32'(drop_count), 32'((drop_m > 255) ? 255 : drop_m));

        // self counter saturation
        in_valid = 1'b1;
        in_data  = 20'h00050;
        for (int i = 0; i < 300; i++) step();
        chk("sat_self",  32'(self_count), 255);
        chk("sat_count", 32'(fifo_count), 0);

        // reset mid-stream with three words held
        flit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = 20'h30010 | 20'(i << 8);
            step();
        end
        in_valid = 1'b0;
        chk("mid_count3", 32'(fifo_count), 3);
        rst = 1'b0;
        #1;
        chk("mid_valid", 32'(flit_valid), 0);
        chk("mid_empty", 32'(empty), 1);
        chk("mid_count", 32'(fifo_count), 0);
        chk("mid_self",  32'(self_count), 0);
        chk("mid_sent",  32'(sent_count), 0);
        chk("mid_drop",  32'(drop_count), 0);
        step();
        rst        = 1'b1;
        flit_ready = 1'b1;
        step();
        step();
        chk("post_valid", 32'(flit_valid), 0);
        in_valid = 1'b1;
        in_data  = 20'h12340;
        step();
        in_valid   = 1'b0;
        chk("post_push_v", 32'(flit_valid), 1);
        chk("post_push_d", 32'(flit_out), 32'h12340);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inject_ni_fifo.md
# inject_ni_fifo

Network-interface injection buffer placed directly downstream of each node's `dataout_buf_N` traffic source. It captures every 20-bit word pulsed on the source's `dataout`/`out_valid` pair into a FIFO. It then presents the words to the local router input port under a valid/ready handshake. The source has no backpressure, so overflow is handled here by dropping and counting.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Must be a power of 2, ≥ 2.
- `NODE_ID`, 0: 4-bit id of this node. Used for self-address filtering.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `in_data`, input, 20: word from the source. Bits [7:4] are the destination node id.
- `in_valid`, input, 1: single-cycle qualifier for `in_data`.
- `flit_out`, output, 20: head-of-FIFO word to the router.
- `flit_valid`, output, 1: `flit_out` holds a valid word.
- `flit_ready`, input, 1: router accepts `flit_out` this cycle.
- `fifo_count`, output, log2(DEPTH)+1: current occupancy.
- `full`, output, 1: `fifo_count == DEPTH`.
- `empty`, output, 1: `fifo_count == 0`.
- `drop_count`, output, 8: words lost to overflow. Saturates at 255.
- `self_count`, output, 8: words discarded because they are self-addressed. Saturates at 255.
- `sent_count`, output, 8: words handed to the router. Saturates at 255.

## Operation
- Storage:
  - Circular buffer with write pointer `wp`, read pointer `rp` and occupancy counter `cnt`.
  - Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Push (`in_valid`=1 in a cycle):
  - Dest == `NODE_ID` (`in_data[7:4] == NODE_ID`): word is not stored. `self_count` increments. Self filtering takes priority over the full check.
  - Otherwise, `full`=1: word is dropped and `drop_count` increments. This applies even if a pop occurs in the same cycle; `full` is judged on the registered `cnt`.
  - Otherwise: `mem[wp] <= in_data`, `wp` increments.
- Pop:
  - Occurs when `flit_valid && flit_ready`.
  - `rp` increments and `sent_count` increments.
  - `flit_ready` while empty has no effect.
- Occupancy update:
  - Accepted push and pop in the same cycle: `cnt` unchanged. This is legal at any non-empty, non-full occupancy, and at empty only if no pop occurs.
  - Push only: `cnt+1`. Pop only: `cnt-1`.
- Output path is first-word fall-through:
  - `flit_out = mem[rp]`.
  - `flit_valid = ~empty`.
- Handshake rules:
  - While `flit_valid`=1 and `flit_ready`=0, `flit_out` and `flit_valid` hold stable.
  - Words leave in strict arrival order. The payload is not modified.
- Counters:
  - All three statistics counters saturate at 8'hFF and never wrap.
  - They clear only on reset.
- Reset (asserted, including mid-transfer):
  - Pointers, `cnt` and all counters clear to 0.
  - `flit_valid`=0, `empty`=1, `full`=0, `fifo_count`=0.
  - `flit_out` reads `mem[0]`; its contents are don't-care and memory is not cleared.
  - Words in flight are lost and not counted.

## Timing
- Push-to-output latency: a word accepted at edge N gives `flit_valid`=1 with that word on `flit_out` after edge N. This is 1 cycle when the FIFO was empty.
- Pop at edge N: the next word, or `flit_valid`=0, appears after edge N.
- Throughput: one push and one pop per cycle sustained.
- `full`, `empty`, `fifo_count` and the statistics counters are registered-state derived. They update after the edge of the causing event.
- Reset release: the first push can be accepted at the first rising edge with `rst`=1.

## Test plan
- Reset/idle: assert `rst`=0 mid-stream with `cnt`=3 -> all outputs 0, `empty`=1; after release, `flit_valid` stays 0 until a new push.
- Order and latency: `NODE_ID`=0, push 20'h00011, 20'h00022, 20'h00033 on consecutive cycles with `flit_ready`=1 -> `flit_out` shows 00011, 00022, 00033 on consecutive cycles, 1 cycle after each push; `sent_count`=3.
- Overflow: `flit_ready`=0, push 10 distinct non-self words with `DEPTH`=8 -> `full`=1 after 8, `drop_count`=2; then drain -> first 8 words emerge in order, `empty`=1.
- Full with simultaneous pop/push: at `cnt`=8 assert `flit_ready`=1 and `in_valid`=1 -> push dropped, `drop_count`+1, `cnt`=7.
- Self-address filter: `NODE_ID`=5, push 20'h00055 then 20'h00066 -> only 00066 is stored, `self_count`=1.
- Backpressure and saturation: toggle `flit_ready` randomly during a 30-word burst and check `flit_out` is stable while stalled; push 300 self-addressed words -> `self_count` holds at 255.
